// File: rtl/memory_arbiter.sv
// Two-requester arbiter sharing one enable/ready memory port (round-robin or fixed priority).
// Latency: grant and mem_enable one edge after request, mN_ready one edge after mem_ready.
// Backpressure: the winner is held until its enable drops; no new enable while mem_ready is high.
module memory_arbiter #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0]    m0_data_out,
    input  logic [1:0]               m0_data_size,
    input  logic                     m0_operation,
    input  logic                     m0_enable,
    output logic [DATA_WIDTH-1:0]    m0_data_in,
    output logic                     m0_ready,
    input  logic [ADDRESS_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0]    m1_data_out,
    input  logic [1:0]               m1_data_size,
    input  logic                     m1_operation,
    input  logic                     m1_enable,
    output logic [DATA_WIDTH-1:0]    m1_data_in,
    output logic                     m1_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_data_out,
    output logic [1:0]               mem_data_size,
    output logic                     mem_operation,
    output logic                     mem_enable,
    input  logic [DATA_WIDTH-1:0]    mem_data_in,
    input  logic                     mem_ready
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND, DRAIN} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   winner;
    logic   grant_vld;
    logic   grant_sel;
    logic   winner_enable;

    // Holding off on mem_ready keeps a new request from overlapping a stale completion.
    always_comb begin
        grant_vld = (m0_enable | m1_enable) & ~mem_ready;
        grant_sel = 1'b0;
        if (m0_enable && m1_enable) begin
            grant_sel = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
        end else if (m1_enable) begin
            grant_sel = 1'b1;
        end
        winner_enable = winner ? m1_enable : m0_enable;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ACCESS;
            ACCESS:  if (mem_ready) state_nxt = RESPOND;
            RESPOND: if (!winner_enable) state_nxt = mem_ready ? DRAIN : IDLE;
            DRAIN:   if (!mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant    <= 1'b1;
            winner        <= 1'b0;
            mem_address   <= '0;
            mem_data_out  <= '0;
            mem_data_size <= '0;
            mem_operation <= 1'b0;
            mem_enable    <= 1'b0;
            m0_data_in    <= '0;
            m1_data_in    <= '0;
            m0_ready      <= 1'b0;
            m1_ready      <= 1'b0;
        end else begin
            if (state == IDLE && grant_vld) begin
                winner        <= grant_sel;
                last_grant    <= grant_sel;
                mem_address   <= grant_sel ? m1_address   : m0_address;
                mem_data_out  <= grant_sel ? m1_data_out  : m0_data_out;
                mem_data_size <= grant_sel ? m1_data_size : m0_data_size;
                mem_operation <= grant_sel ? m1_operation : m0_operation;
                mem_enable    <= 1'b1;
            end
            if (state == ACCESS && mem_ready) begin
                mem_enable <= 1'b0;
                if (winner) begin
                    m1_ready <= 1'b1;
                    if (!mem_operation) m1_data_in <= mem_data_in;
                end else begin
                    m0_ready <= 1'b1;
                    if (!mem_operation) m0_data_in <= mem_data_in;
                end
            end
            if (state == RESPOND && !winner_enable) begin
                if (winner) m1_ready <= 1'b0;
                else        m0_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a round-robin and a fixed-priority instance behind one RAM model.
module tb_memory_arbiter;
    logic        clock, reset;
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic [1:0]  m_size [2];
    logic        m_op   [2];
    logic        m_en   [2];
    logic        sel_fp, resp_rdy, spur;
    logic [31:0] mem_rdat;
    wire         mem_ready    = resp_rdy | spur;
    wire         rr_mem_ready = mem_ready & ~sel_fp;
    wire         fp_mem_ready = mem_ready & sel_fp;

    logic [31:0] rr_m0_din, rr_m1_din, rr_addr, rr_wdat, fp_m0_din, fp_m1_din, fp_addr, fp_wdat;
    logic [1:0]  rr_size, fp_size;
    logic        rr_m0_rdy, rr_m1_rdy, rr_op, rr_en, fp_m0_rdy, fp_m1_rdy, fp_op, fp_en;

    wire [31:0] o_m0_din        = sel_fp ? fp_m0_din : rr_m0_din;
    wire [31:0] o_m1_din        = sel_fp ? fp_m1_din : rr_m1_din;
    wire [31:0] o_mem_address   = sel_fp ? fp_addr   : rr_addr;
    wire [31:0] o_mem_data_out  = sel_fp ? fp_wdat   : rr_wdat;
    wire [1:0]  o_mem_data_size = sel_fp ? fp_size   : rr_size;
    wire        o_mem_operation = sel_fp ? fp_op     : rr_op;
    wire        o_mem_enable    = sel_fp ? fp_en     : rr_en;
    wire        o_m0_ready      = sel_fp ? fp_m0_rdy : rr_m0_rdy;
    wire        o_m1_ready      = sel_fp ? fp_m1_rdy : rr_m1_rdy;

    memory_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) dut (
        .clock(clock), .reset(reset),
        .m0_address(m_addr[0]), .m0_data_out(m_wdat[0]), .m0_data_size(m_size[0]),
        .m0_operation(m_op[0]), .m0_enable(m_en[0]), .m0_data_in(rr_m0_din), .m0_ready(rr_m0_rdy),
        .m1_address(m_addr[1]), .m1_data_out(m_wdat[1]), .m1_data_size(m_size[1]),
        .m1_operation(m_op[1]), .m1_enable(m_en[1]), .m1_data_in(rr_m1_din), .m1_ready(rr_m1_rdy),
        .mem_address(rr_addr), .mem_data_out(rr_wdat), .mem_data_size(rr_size),
        .mem_operation(rr_op), .mem_enable(rr_en), .mem_data_in(mem_rdat), .mem_ready(rr_mem_ready)
    );

    memory_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
        .clock(clock), .reset(reset),
        .m0_address(m_addr[0]), .m0_data_out(m_wdat[0]), .m0_data_size(m_size[0]),
        .m0_operation(m_op[0]), .m0_enable(m_en[0]), .m0_data_in(fp_m0_din), .m0_ready(fp_m0_rdy),
        .m1_address(m_addr[1]), .m1_data_out(m_wdat[1]), .m1_data_size(m_size[1]),
        .m1_operation(m_op[1]), .m1_enable(m_en[1]), .m1_data_in(fp_m1_din), .m1_ready(fp_m1_rdy),
        .mem_address(fp_addr), .mem_data_out(fp_wdat), .mem_data_size(fp_size),
        .mem_operation(fp_op), .mem_enable(fp_en), .mem_data_in(mem_rdat), .mem_ready(fp_mem_ready)
    );

    typedef struct {
        int          who;
        logic [31:0] dat;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] ram [logic [31:0]];
    logic [31:0] exp_din [2];
    int          rem [2];
    int          n_cmp, n_bad, resp_delay, en_viol;
    logic [31:0] cap_addr, cap_dat;
    logic [1:0]  cap_size;
    logic        cap_op;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Responder: completes resp_delay edges after it first sees enable, drops ready once enable is gone.
    initial begin
        logic        en_s, op_s, rdy_s, en_prev, rdy_prev;
        logic [31:0] a_s, d_s;
        logic [1:0]  sz_s;
        int          cnt;
        resp_rdy = 1'b0; mem_rdat = '0; en_prev = 1'b0; rdy_prev = 1'b0; cnt = 0;
        forever begin
            @(posedge clock);
            en_s = o_mem_enable; op_s = o_mem_operation; a_s = o_mem_address;
            d_s = o_mem_data_out; sz_s = o_mem_data_size; rdy_s = mem_ready;
            #1;
            if (en_s && !en_prev && rdy_prev) en_viol++;
            en_prev = en_s;
            rdy_prev = rdy_s;
            if (reset || !en_s) begin
                resp_rdy = 1'b0;
                cnt = 0;
            end else if (!resp_rdy) begin
                cnt++;
                if (cnt >= resp_delay) begin
                    cap_addr = a_s; cap_dat = d_s; cap_size = sz_s; cap_op = op_s;
                    if (op_s) begin
                        ram[a_s] = d_s;
                        mem_rdat = '0;
                    end else begin
                        mem_rdat = ram.exists(a_s) ? ram[a_s] : 32'h0;
                    end
                    resp_rdy = 1'b1;
                end
            end
        end
    end

    task automatic issue(input int n, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic op);
        m_addr[n] = a; m_wdat[n] = d; m_size[n] = s; m_op[n] = op; m_en[n] = 1'b1;
    endtask

    task automatic expect_txn(input int w, input logic [31:0] d);
        exp_t e;
        e.who = w;
        e.dat = d;
        sb.push_back(e);
        exp_din[w] = d;
    endtask

    task automatic do_reset;
        m_en[0] = 1'b0; m_en[1] = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_din[0] = '0; exp_din[1] = '0;
        sb.delete();
        rem[0] = 0; rem[1] = 0;
        resp_delay = 1;
    endtask

    // Waits for a completion, releases that requester, optionally re-requests with the same fields.
    task automatic complete_one(output int who, output logic [31:0] d, output bit ok);
        ok = 1'b0; who = -1; d = '0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (o_m0_ready || o_m1_ready) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        who = o_m0_ready ? 0 : 1;
        d = (who == 0) ? o_m0_din : o_m1_din;
        m_en[who] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (!(o_m0_ready || o_m1_ready)) begin ok = 1'b1; break; end
        end
        if (ok && rem[who] > 0) begin
            rem[who]--;
            m_en[who] = 1'b1;
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({o_mem_enable, o_m0_ready, o_m1_ready, o_mem_operation, o_mem_data_size} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got en/r0/r1/op/size=%b required 000000",
                     {o_mem_enable, o_m0_ready, o_m1_ready, o_mem_operation, o_mem_data_size});
        end
        n_cmp++;
        if ({o_mem_address, o_mem_data_out} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mem_bus: got addr=%h wdat=%h required 0", o_mem_address, o_mem_data_out);
        end
        n_cmp++;
        if ({o_m0_din, o_m1_din} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_data_in: got m0=%h m1=%h required 0", o_m0_din, o_m1_din);
        end
    endtask

    task automatic test_single_read;
        exp_t e;
        bit   ok;
        do_reset;
        expect_txn(0, 32'hDEADBEEF);
        issue(0, 32'h100, 32'h0, 2'd2, 1'b0);
        @(posedge clock); #1;
        n_cmp++;
        if (o_mem_enable !== 1'b1 || o_mem_address !== 32'h100) begin
            n_bad++;
            $display("FAIL single_grant: got en=%b addr=%h required 1/00000100", o_mem_enable, o_mem_address);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (o_m0_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early_ready: got %b required 0", o_m0_ready);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (o_m0_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: m0_ready got %b required 1 after edge 3", o_m0_ready);
        end
        e = sb.pop_front();
        n_cmp++;
        if (o_m0_din !== e.dat) begin
            n_bad++;
            $display("FAIL single_data: got %h required %h", o_m0_din, e.dat);
        end
        n_cmp++;
        if (o_m1_ready !== 1'b0 || o_m1_din !== 32'h0) begin
            n_bad++;
            $display("FAIL single_loser: got r1=%b d1=%h required 0/0", o_m1_ready, o_m1_din);
        end
        m_en[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (!o_m0_ready) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_release: m0_ready got 1 required 0 after enable drop");
        end
    endtask

    task automatic test_round_robin;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok;
        do_reset;
        issue(0, 32'h10, 32'h11, 2'd0, 1'b1);
        issue(1, 32'h20, 32'h0, 2'd2, 1'b0);
        rem[0] = 1;
        expect_txn(0, exp_din[0]);
        expect_txn(1, 32'hCAFE0020);
        expect_txn(0, exp_din[0]);
        for (int k = 0; k < 3; k++) begin
            complete_one(who, d, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || who !== e.who || d !== e.dat) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                         k, ok, who, d, e.who, e.dat);
            end
        end
        issue(0, 32'h10, 32'h11, 2'd0, 1'b1);
        issue(1, 32'h20, 32'h0, 2'd2, 1'b0);
        expect_txn(1, 32'hCAFE0020);
        expect_txn(0, exp_din[0]);
        for (int k = 0; k < 2; k++) begin
            complete_one(who, d, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || who !== e.who || d !== e.dat) begin
                n_bad++;
                $display("FAIL rr_alternate[%0d]: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                         k, ok, who, d, e.who, e.dat);
            end
        end
    endtask

    task automatic test_mmio_write;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok;
        issue(0, 32'hFFFFFD, 32'h01, 2'd0, 1'b1);
        expect_txn(0, exp_din[0]);
        complete_one(who, d, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || who !== e.who || d !== e.dat) begin
            n_bad++;
            $display("FAIL mmio_done: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                     ok, who, d, e.who, e.dat);
        end
        n_cmp++;
        if ({cap_addr, cap_dat, cap_size, cap_op} !== {32'hFFFFFD, 32'h1, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL mmio_fields: got %h/%h/%0d/%b required 00fffffd/00000001/0/1",
                     cap_addr, cap_dat, cap_size, cap_op);
        end
        n_cmp++;
        if (o_m1_din !== exp_din[1]) begin
            n_bad++;
            $display("FAIL mmio_m1_din: got %h required %h", o_m1_din, exp_din[1]);
        end
    endtask

    task automatic test_slow_responder;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok, stable;
        resp_delay = 5;
        en_viol = 0;
        expect_txn(0, 32'hDEADBEEF);
        expect_txn(1, 32'hCAFE0020);
        issue(0, 32'h100, 32'h0, 2'd2, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (o_mem_enable) begin ok = 1'b1; break; end
        end
        stable = ok;
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            if (c == 1) issue(1, 32'h20, 32'h0, 2'd2, 1'b0);
            if (o_m0_ready) begin ok = 1'b1; break; end
            if (o_mem_address !== 32'h100 || o_mem_operation !== 1'b0 || o_mem_data_size !== 2'd2 ||
                o_mem_enable !== 1'b1 || o_m1_ready !== 1'b0) stable = 1'b0;
        end
        n_cmp++;
        if (!stable || !ok) begin
            n_bad++;
            $display("FAIL slow_stable: got stable=%0d done=%0d required 1/1", stable, ok);
        end
        e = sb.pop_front();
        n_cmp++;
        if (o_m0_din !== e.dat) begin
            n_bad++;
            $display("FAIL slow_m0_data: got %h required %h", o_m0_din, e.dat);
        end
        m_en[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (!o_m0_ready) break;
        end
        complete_one(who, d, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || who !== e.who || d !== e.dat) begin
            n_bad++;
            $display("FAIL slow_m1_after: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                     ok, who, d, e.who, e.dat);
        end
        n_cmp++;
        if (en_viol !== 0) begin
            n_bad++;
            $display("FAIL slow_enable_vs_ready: got %0d enables raised over high mem_ready required 0", en_viol);
        end
        resp_delay = 1;
    endtask

    task automatic test_early_drop;
        int          hi;
        logic [31:0] d;
        bit          ok;
        resp_delay = 3;
        issue(1, 32'h24, 32'h0, 2'd2, 1'b0);
        exp_din[1] = 32'h5A5A1234;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (o_mem_enable) begin ok = 1'b1; break; end
        end
        m_en[1] = 1'b0;
        hi = 0; d = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (o_m1_ready) begin hi++; d = o_m1_din; end
        end
        n_cmp++;
        if (!ok || hi != 1) begin
            n_bad++;
            $display("FAIL early_drop_pulse: got granted=%0d ready_cycles=%0d required 1/1", ok, hi);
        end
        n_cmp++;
        if (d !== exp_din[1]) begin
            n_bad++;
            $display("FAIL early_drop_data: got %h required %h", d, exp_din[1]);
        end
        resp_delay = 1;
    endtask

    task automatic test_reset_mid;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok;
        resp_delay = 5;
        issue(0, 32'h100, 32'h0, 2'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (o_mem_enable) break;
        end
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({o_mem_enable, o_m0_ready, o_m1_ready} !== 3'b0 || o_mem_address !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mid_ctrl: got en=%b r0=%b r1=%b addr=%h required 0",
                     o_mem_enable, o_m0_ready, o_m1_ready, o_mem_address);
        end
        n_cmp++;
        if ({o_m0_din, o_m1_din} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mid_data: got m0=%h m1=%h required 0", o_m0_din, o_m1_din);
        end
        m_en[0] = 1'b0; m_en[1] = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_din[0] = '0; exp_din[1] = '0;
        sb.delete();
        resp_delay = 1;
        issue(0, 32'h100, 32'h0, 2'd2, 1'b0);
        issue(1, 32'h20, 32'h0, 2'd2, 1'b0);
        expect_txn(0, 32'hDEADBEEF);
        expect_txn(1, 32'hCAFE0020);
        for (int k = 0; k < 2; k++) begin
            complete_one(who, d, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || who !== e.who || d !== e.dat) begin
                n_bad++;
                $display("FAIL reset_recover[%0d]: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                         k, ok, who, d, e.who, e.dat);
            end
        end
    endtask

    task automatic test_spurious;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok, quiet;
        quiet = 1'b1;
        spur = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            if (o_mem_enable || o_m0_ready || o_m1_ready) quiet = 1'b0;
        end
        spur = 1'b0;
        n_cmp++;
        if (!quiet) begin
            n_bad++;
            $display("FAIL spurious_idle: outputs moved on idle mem_ready, required all low");
        end
        issue(1, 32'h24, 32'h0, 2'd2, 1'b0);
        expect_txn(1, 32'h5A5A1234);
        complete_one(who, d, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || who !== e.who || d !== e.dat) begin
            n_bad++;
            $display("FAIL after_spurious: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                     ok, who, d, e.who, e.dat);
        end
    endtask

    task automatic test_fixed_priority;
        exp_t        e;
        int          who;
        logic [31:0] d;
        bit          ok;
        sel_fp = 1'b1;
        do_reset;
        issue(0, 32'h100, 32'h0, 2'd2, 1'b0);
        issue(1, 32'h20, 32'h0, 2'd2, 1'b0);
        rem[0] = 3;
        repeat (4) expect_txn(0, 32'hDEADBEEF);
        expect_txn(1, 32'hCAFE0020);
        for (int k = 0; k < 5; k++) begin
            complete_one(who, d, ok);
            e = sb.pop_front();
            n_cmp++;
            if (!ok || who !== e.who || d !== e.dat) begin
                n_bad++;
                $display("FAIL fp_order[%0d]: got ok=%0d who=%0d data=%h required who=%0d data=%h",
                         k, ok, who, d, e.who, e.dat);
            end
        end
        sel_fp = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; en_viol = 0; resp_delay = 1;
        sel_fp = 1'b0; spur = 1'b0; reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            m_addr[n] = '0; m_wdat[n] = '0; m_size[n] = '0; m_op[n] = 1'b0; m_en[n] = 1'b0;
            exp_din[n] = '0; rem[n] = 0;
        end
        ram[32'h100] = 32'hDEADBEEF;
        ram[32'h20]  = 32'hCAFE0020;
        ram[32'h24]  = 32'h5A5A1234;
        test_reset;
        test_single_read;
        test_round_robin;
        test_mmio_write;
        test_slow_responder;
        test_early_drop;
        test_reset_mid;
        test_spurious;
        test_fixed_priority;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
